// File: rtl/uart_tx_arbiter.sv
// Two-port byte arbiter in front of a single txuart: per-port FIFOs drained
// round-robin through the transmitter's write/busy handshake, plus a CPU status word.
module uart_tx_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BUSY_WAIT  = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        p0_push_i,
  input  logic [7:0]  p0_data_i,
  output logic        p0_full_o,
  input  logic        p1_push_i,
  input  logic [7:0]  p1_data_i,
  output logic        p1_full_o,
  output logic        uart_wr_o,
  output logic [7:0]  uart_data_o,
  input  logic        uart_busy_i,
  output logic [31:0] status_o,
  input  logic        ovf_clr_i
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WAIT_W = (BUSY_WAIT == 0) ? 1 : $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  logic [7:0]            mem_q [2][FIFO_DEPTH];
  logic [1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            full_q, full_d;
  logic [1:0]            ovf_q, ovf_d;
  logic [1:0]            push, push_ok, pop, not_empty;
  logic [1:0][7:0]       push_data;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [7:0]            data_q, data_d;
  logic                  wr_q, wr_d;
  logic [WAIT_W-1:0]     wait_q, wait_d, wait_inc;
  logic                  busy_q, busy_d;
  logic                  win;

  assign push      = {p1_push_i, p0_push_i};
  assign push_data = {p1_data_i, p0_data_i};
  assign push_ok   = push & ~full_q;
  assign not_empty = {(cnt_q[1] != '0), (cnt_q[0] != '0)};

  // FIFO bookkeeping; a push into a full FIFO is dropped and flags overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    full_d   = full_q;
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (pop[i])     rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      if (push_ok[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!push_ok[i] && pop[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      if (push[i] && full_q[i]) ovf_d[i] = 1'b1;
      else if (ovf_clr_i)       ovf_d[i] = 1'b0;
      full_d[i] = (cnt_d[i] == CNT_W'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (push_ok[i]) mem_q[i][wr_ptr_q[i]] <= push_data[i];
    end
  end

  // Scheduler: pop in IDLE, strobe in ISSUE, then follow txuart busy
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    wr_d         = 1'b0;
    wait_d       = wait_q;
    pop          = '0;
    win          = 1'b0;
    wait_inc     = wait_q + WAIT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!uart_busy_i && (|not_empty)) begin
          win          = (&not_empty) ? ~last_grant_q : not_empty[1];
          pop[win]     = 1'b1;
          data_d       = mem_q[win][rd_ptr_q[win]];
          last_grant_d = win;
          wr_d         = 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_d  = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (uart_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_W'(BUSY_WAIT)) state_d = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!uart_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE) || (cnt_d[0] != '0) || (cnt_d[1] != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      wr_q         <= 1'b0;
      wait_q       <= '0;
      busy_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      full_q       <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      wr_q         <= wr_d;
      wait_q       <= wait_d;
      busy_q       <= busy_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      full_q       <= full_d;
      ovf_q        <= ovf_d;
    end
  end

  assign p0_full_o   = full_q[0];
  assign p1_full_o   = full_q[1];
  assign uart_wr_o   = wr_q;
  assign uart_data_o = data_q;
  assign status_o    = {22'b0, busy_q, full_q[0], ovf_q[0], ovf_q[1], 6'b0};

endmodule
